// File: rtl/xc6lx9_run_ctrl.sv
// Run/halt/single-step sequencer for the prco core: debounces the PORTC3 button,
// classifies short/long presses and drives the core reset, clock-enable and LEDs.
module xc6lx9_run_ctrl #(
    parameter int DEBOUNCE_CYCLES = 25000,
    parameter int LONG_CYCLES     = 25000000,
    parameter int RST_CYCLES      = 16
) (
    input  logic       clk50,
    input  logic       rst_n,
    input  logic       btn_raw,
    input  logic       core_halt_req,
    input  logic [7:0] core_leds,
    output logic       core_rst_n,
    output logic       core_en,
    output logic [7:0] leds,
    output logic [1:0] state_o
);

    localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HOLD_W = $clog2(LONG_CYCLES + 1);
    localparam int RST_W  = $clog2(RST_CYCLES + 1);

    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);
    localparam logic [RST_W-1:0]  RST_LAST  = RST_W'(RST_CYCLES - 1);

    typedef enum logic [1:0] {
        RST_HOLD = 2'd0,
        RUN      = 2'd1,
        HALT     = 2'd2,
        STEP     = 2'd3
    } state_t;

    state_t            state, state_next;
    logic [1:0]        sync_q;
    logic              btn_sync;
    logic              btn_stable;
    logic [DB_W-1:0]   db_cnt;
    logic [HOLD_W-1:0] hold_cnt;
    logic [RST_W-1:0]  rst_cnt, rst_cnt_next;
    logic [6:0]        step_count, step_next;
    logic              db_done;
    logic              long_press;
    logic              short_press;
    logic              core_rst_n_next;
    logic              core_en_next;
    logic [7:0]        leds_next;

    assign btn_sync = sync_q[1];
    assign db_done  = (btn_sync != btn_stable) && (db_cnt == DB_LAST);

    // Both pulses are decoded from the edge at which btn_stable/hold_cnt update,
    // so the FSM reacts at the same edge the debounced button changes.
    assign long_press  = btn_stable && (hold_cnt == HOLD_LAST);
    assign short_press = btn_stable && !btn_sync && db_done && (hold_cnt < HOLD_MAX);

    always_ff @(posedge clk50) begin
        if (!rst_n) begin
            sync_q     <= 2'b00;
            btn_stable <= 1'b0;
            db_cnt     <= '0;
            hold_cnt   <= '0;
        end else begin
            sync_q <= {sync_q[0], btn_raw};
            if (btn_sync == btn_stable) begin
                db_cnt <= '0;
            end else if (db_done) begin
                btn_stable <= btn_sync;
                db_cnt     <= '0;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end
            if (!btn_stable) begin
                hold_cnt <= '0;
            end else if (hold_cnt != HOLD_MAX) begin
                hold_cnt <= hold_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        state_next   = state;
        rst_cnt_next = rst_cnt;
        step_next    = step_count;
        if (long_press) begin
            state_next   = RST_HOLD;
            rst_cnt_next = '0;
        end else begin
            case (state)
                RST_HOLD: begin
                    if (rst_cnt == RST_LAST) begin
                        state_next   = RUN;
                        rst_cnt_next = '0;
                    end else begin
                        rst_cnt_next = rst_cnt + 1'b1;
                    end
                end
                RUN: begin
                    if (short_press || core_halt_req) begin
                        state_next = HALT;
                        step_next  = 7'd0;
                    end
                end
                HALT: begin
                    if (short_press) state_next = STEP;
                end
                STEP: begin
                    state_next = HALT;
                    step_next  = step_count + 7'd1;
                end
                default: state_next = RST_HOLD;
            endcase
        end

        // Outputs are registered from the next state so they line up with state_o.
        core_rst_n_next = (state_next != RST_HOLD);
        core_en_next    = (state_next == RUN) || (state_next == STEP);
        case (state_next)
            RST_HOLD: leds_next = 8'hFF;
            RUN:      leds_next = core_leds;
            default:  leds_next = {step_next, 1'b1};
        endcase
    end

    always_ff @(posedge clk50) begin
        if (!rst_n) begin
            state      <= RST_HOLD;
            rst_cnt    <= '0;
            step_count <= 7'd0;
            core_rst_n <= 1'b0;
            core_en    <= 1'b0;
            leds       <= 8'hFF;
        end else begin
            state      <= state_next;
            rst_cnt    <= rst_cnt_next;
            step_count <= step_next;
            core_rst_n <= core_rst_n_next;
            core_en    <= core_en_next;
            leds       <= leds_next;
        end
    end

    assign state_o = state;

endmodule

// File: doc/xc6lx9_run_ctrl.md
Name: xc6lx9_run_ctrl

Overview:
- Board-level run/halt/step sequencer for the prco core on the xc6lx9 miniSpartan+ top.
- Takes the raw PORTC3 push-button and the core's halt request, and produces the core reset, the core clock-enable and the board LED drive.
- Button behaviour:
  - short press: halts the core, or single-steps it when already halted;
  - long press: re-resets the core.

Parameters:
- DEBOUNCE_CYCLES, 25000: consecutive stable cycles required before the debounced button changes (0.5 ms at 50 MHz).
- LONG_CYCLES, 25000000: debounced-held cycles that constitute a long press (0.5 s).
- RST_CYCLES, 16: cycles core_rst_n is held low in RST_HOLD.

Ports:
- clk50  input  1  50 MHz system clock; all logic on the rising edge.
- rst_n  input  1  synchronous active-low reset.
- btn_raw  input  1  PORTC3 button, active-high, asynchronous/bouncy.
- core_halt_req  input  1  core request to halt (HALT instruction), level, sampled each cycle.
- core_leds  input  8  core output-port value destined for the LEDs.
- core_rst_n  output  1  active-low reset to the core, registered.
- core_en  output  1  core clock-enable, registered.
- leds  output  8  LED drive, registered.
- state_o  output  2  current FSM state: 0 RST_HOLD, 1 RUN, 2 HALT, 3 STEP.

Behaviour:
- Reset (rst_n=0 at an edge): state=RST_HOLD, core_rst_n=0, core_en=0, leds=8'hFF, all counters 0, debounced button=0, step_count=0. Reset applied mid-operation overrides everything at that edge.
- Synchroniser: 2-FF chain on btn_raw gives btn_sync.
- Debounce:
  - btn_stable takes btn_sync once btn_sync has differed from btn_stable for DEBOUNCE_CYCLES consecutive cycles.
  - The counter clears whenever btn_sync equals btn_stable.
  - Latency from a clean btn_raw edge to btn_stable is 2+DEBOUNCE_CYCLES cycles.
- Press classification:
  - hold_cnt counts cycles while btn_stable=1 and saturates at LONG_CYCLES.
  - long_press: single-cycle pulse when hold_cnt reaches LONG_CYCLES.
  - short_press: single-cycle pulse on the btn_stable falling edge if hold_cnt<LONG_CYCLES. Release after a long press generates nothing.
  - hold_cnt clears on release.
- FSM (long_press has priority over every other transition in every state):
  - RST_HOLD: core_rst_n=0, core_en=0, leds=8'hFF. Go to RUN after RST_CYCLES cycles in state; rst_cnt restarts on every entry.
  - RUN: core_rst_n=1, core_en=1, leds=core_leds (registered, 1-cycle latency). Go to HALT on short_press or core_halt_req; both in the same cycle is a single transition.
  - HALT: core_en=0, leds={step_count[6:0],1'b1}, core_halt_req ignored. On entry from RUN, step_count=0. Go to STEP on short_press.
  - STEP: core_en=1 for exactly one cycle, step_count increments (7-bit, wraps 127→0), then unconditionally back to HALT. short_press arriving during STEP is dropped.
  - long_press from any state: enter RST_HOLD; core_rst_n drops and core_en drops at the next edge.
- Exit from HALT to RUN is only via long press (re-reset).
- Outputs change only at clk50 edges; no combinational path from any input to any output.

Test Plan (bench overrides DEBOUNCE_CYCLES=4, LONG_CYCLES=64, RST_CYCLES=8):
1. Release rst_n after 3 cycles, core_leds=8'hA5 → core_rst_n low exactly 8 cycles, state 0→1; core_en=1 and leds=8'hA5 from the following cycle.
2. In RUN, btn_raw glitch 1,0,1,0 on consecutive cycles, then low → btn_stable never rises, state remains RUN, no pulses.
3. In RUN, btn_raw high 20 cycles then low → state=HALT 2+4 cycles after release edge, core_en=0, leds=8'h01. A second identical press → core_en high exactly one cycle, state 3 then 2, leds=8'h03.
4. btn_raw high 100 cycles → at hold_cnt=64, state=RST_HOLD, core_rst_n low 8 cycles, then RUN. Release produces no HALT.
5. In RUN, core_halt_req=1 for one cycle → state=HALT next edge. Assert rst_n=0 while in HALT → next edge state=0, leds=8'hFF, core_en=0.
6. From HALT issue 128 short presses → step_count wraps; leds=8'h01 and exactly 128 single-cycle core_en pulses counted.
